// File: rtl/serial_normalizer.sv
// serial_normalizer: shifts a word left one bit per cycle until normalized and reports the shift count.
// Latency: n+1 edges from accept (1 edge for a zero word in unsigned mode), at most W edges.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Optional macro SERIAL_NORMALIZER_SIGNED_EN adds sgn.
module serial_normalizer #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  i,
`ifdef SERIAL_NORMALIZER_SIGNED_EN
  input  logic          sgn,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  o,
  output logic [CW-1:0] n
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [CW-1:0] CNT_W   = CW'(W);
  localparam logic [CW-1:0] CNT_WM1 = CW'(W - 1);

  state_t        state, state_nxt;
  logic [W-1:0]  sreg, sreg_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          zero_stop;
  logic          norm_stop;

`ifdef SERIAL_NORMALIZER_SIGNED_EN
  logic sgn_q, sgn_nxt;

  // Stop conditions: signed mode stops on a sign/next-bit difference or after W-1 shifts, no zero shortcut.
  always_comb begin
    zero_stop = 1'b0;
    norm_stop = 1'b0;
    if (sgn_q) begin
      norm_stop = (sreg[W-1] != sreg[W-2]) || (cnt == CNT_WM1);
    end else begin
      zero_stop = (sreg == '0);
      norm_stop = sreg[W-1];
    end
  end
`else
  // Stop conditions: a zero word ends immediately, otherwise stop once the MSB is set.
  always_comb begin
    zero_stop = (sreg == '0);
    norm_stop = sreg[W-1];
  end
`endif

  // Next-state and datapath update; defaults hold every register.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
`ifdef SERIAL_NORMALIZER_SIGNED_EN
    sgn_nxt   = sgn_q;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          sreg_nxt  = i;
          cnt_nxt   = '0;
`ifdef SERIAL_NORMALIZER_SIGNED_EN
          sgn_nxt   = sgn;
`endif
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (zero_stop) begin
          cnt_nxt   = CNT_W;
          state_nxt = DONE;
        end else if (norm_stop) begin
          state_nxt = DONE;
        end else begin
          // Bits leaving the MSB are zero (unsigned) or copies of the sign (signed), so nothing is lost.
          sreg_nxt = {sreg[W-2:0], 1'b0};
          cnt_nxt  = cnt + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, shift register and counter; reset discards any in-flight word.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
`ifdef SERIAL_NORMALIZER_SIGNED_EN
      sgn_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
`ifdef SERIAL_NORMALIZER_SIGNED_EN
      sgn_q <= sgn_nxt;
`endif
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign o         = sreg;
  assign n         = cnt;

endmodule
